matvec_mac_sequencer: RTL and testbench
=======================================

// Module: matvec_mac_sequencer
// PURPOSE
//  Sequences a single shared multiply-accumulator to compute y = M*v for an NxN matrix of
//  unsigned EW-bit elements (the packed 27-bit constant-matrix word from the matrix source)
//  and an N-element vector. One MAC per cycle, row by row. Each row result is returned over
//  a valid/ready stream, followed by a one-cycle done pulse.
// PARAMETERS
//  EW     3                           element width, unsigned, matrix and vector
//  N      3                           matrix dimension; N*N elements, N results
//  ACC_W  2*EW+$clog2(N)  (8)         accumulator/result width; overflow impossible
//  IDX_W  ($clog2(N)>0?$clog2(N):1)   row/column index width (2)
// PORTS
//  clk        in   1         rising-edge clock
//  rst        in   1         reset, asynchronous, active-high
//  start      in   1         begin job; sampled only in IDLE
//  mat_in     in   N*N*EW    packed matrix; M[r][c] = mat_in[EW*(N*r+c) +: EW]
//  vec_in     in   N*EW      packed vector; v[c] = vec_in[EW*c +: EW]
//  busy       out  1         high from the cycle after start is accepted until done
//  res_valid  out  1         res_data/res_row valid
//  res_ready  in   1         consumer accepts the result on clk edge when valid&ready
//  res_data   out  ACC_W     row result sum_c M[r][c]*v[c]
//  res_row    out  IDX_W     row index r of res_data
//  done       out  1         one-cycle pulse after the last row handshake
// BEHAVIOUR
//  - Reset (async, any state): state=IDLE; busy, res_valid, done = 0; res_data, res_row,
//    row, col, acc = 0; captured matrix/vector regs = 0. Reset mid-job aborts; no done.
//  - FSM: IDLE -> MAC -> OUT -> (MAC | IDLE).
//  - IDLE: on edge with start=1, capture mat_in/vec_in; row=0, col=0, acc=0; ->MAC; busy=1.
//    start is ignored in every other state; inputs may then change freely.
//  - MAC: each edge acc += M[row][col]*v[col]; col++. On edge with col==N-1, the final sum is
//    written to res_data, res_row=row, res_valid=1, ->OUT. Product is 2*EW bits, zero-extended.
//  - OUT: res_valid, res_data, res_row held stable until the handshake edge (valid&ready).
//    On handshake: res_valid=0; if row==N-1 -> IDLE, busy=0, done=1 for exactly one cycle;
//    else row++, col=0, acc=0 -> MAC.
//  - res_ready while res_valid=0 has no effect. done and res_valid are never both high.
//  - Latency (N=3): start sampled at edge E0; res_valid high after E3. With res_ready tied
//    high, each row takes N+1=4 cycles; done is high in the cycle after E12. A new start is
//    accepted in the done cycle (state is IDLE).
//  - Back-pressure: OUT stalls indefinitely; no results are lost or reordered.
// CONFIGURATION
//  - MATVEC_TRANSPOSE_EN defined: computes y = M^T*v, i.e. the MAC operand is M[col][row]
//    (element index N*col+row). Ports and timing unchanged.
//  - Not defined: y = M*v as specified above (operand M[row][col]).
// TESTING
//  1. rst pulse mid-idle -> all outputs 0. Then M elements k0..k8 = 1,2,3,3,2,1,1,2,3,
//     v = (1,1,1), ready=1 -> results (r0,6),(r1,6),(r2,6); done after E12.
//  2. Same M, v = (1,2,3) -> 14,10,14; with MATVEC_TRANSPOSE_EN -> 10,12,14.
//  3. All M = 7, all v = 7 -> each result 147 (8'h93); no overflow.
//  4. res_ready held low for 5 cycles in each OUT -> res_valid/res_data stable throughout;
//     same three values in order; done exactly once.
//  5. start re-pulsed while busy, and mat_in/vec_in changed mid-job -> ignored; results
//     match the values captured at E0.
//  6. rst asserted while in MAC of row 1 -> outputs 0 immediately; no done. Next start
//     runs a full, correct job.

Source files
------------

// File: rtl/matvec_mac_sequencer_if.sv
// Result stream between the mat-vec sequencer and its consumer.
// Strict valid/ready: a word transfers on the clk edge where res_valid & res_ready are both high.
interface matvec_mac_sequencer_if #(
  parameter int ACC_W = 8,
  parameter int IDX_W = 2
);
  logic             res_valid;
  logic             res_ready;
  logic [ACC_W-1:0] res_data;
  logic [IDX_W-1:0] res_row;

  modport master (
    output res_valid,
    output res_data,
    output res_row,
    input  res_ready
  );

  modport slave (
    input  res_valid,
    input  res_data,
    input  res_row,
    output res_ready
  );
endinterface

// File: rtl/matvec_mac_sequencer.sv
// Shared-MAC sequencer computing y = M*v row by row, one MAC per cycle.
// Define MATVEC_TRANSPOSE_EN to compute y = M^T*v instead (same ports and timing).
module matvec_mac_sequencer #(
  parameter int EW    = 3,
  parameter int N     = 3,
  parameter int ACC_W = 2*EW + $clog2(N),
  parameter int IDX_W = ($clog2(N) > 0 ? $clog2(N) : 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [N*N*EW-1:0]   mat_in,
  input  logic [N*EW-1:0]     vec_in,
  output logic                busy,
  output logic                done,
  output logic [1:0]          state_dbg,
  matvec_mac_sequencer_if.master res_if
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MAC  = 2'd1,
    S_OUT  = 2'd2
  } state_t;

  localparam logic [IDX_W-1:0] LAST = IDX_W'(N-1);

  state_t             state, state_next;
  logic [N*N*EW-1:0]  mat_q;
  logic [N*EW-1:0]    vec_q;
  logic [IDX_W-1:0]   row, col;
  logic [ACC_W-1:0]   acc;
  logic [ACC_W-1:0]   res_data_q;
  logic [IDX_W-1:0]   res_row_q;
  logic               res_valid_q;

  logic [EW-1:0]      m_arr [N][N];
  logic [EW-1:0]      v_arr [N];
  logic [EW-1:0]      m_el, v_el;
  logic [2*EW-1:0]    prod;
  logic [ACC_W-1:0]   acc_sum;
  logic               handshake;

  for (genvar r = 0; r < N; r++) begin : g_row
    for (genvar c = 0; c < N; c++) begin : g_col
      assign m_arr[r][c] = mat_q[EW*(N*r+c) +: EW];
    end
    assign v_arr[r] = vec_q[EW*r +: EW];
  end

`ifdef MATVEC_TRANSPOSE_EN
  assign m_el = m_arr[col][row];
`else
  assign m_el = m_arr[row][col];
`endif
  assign v_el    = v_arr[col];
  assign prod    = (2*EW)'(m_el) * (2*EW)'(v_el);
  assign acc_sum = acc + ACC_W'(prod);

  assign handshake = res_valid_q & res_if.res_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (start) state_next = S_MAC;
      S_MAC:   if (col == LAST) state_next = S_OUT;
      S_OUT:   if (handshake) state_next = (row == LAST) ? S_IDLE : S_MAC;
      default: state_next = S_IDLE;
    endcase
  end

  // Datapath; done is a pulse, so it defaults low every edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mat_q       <= '0;
      vec_q       <= '0;
      row         <= '0;
      col         <= '0;
      acc         <= '0;
      res_data_q  <= '0;
      res_row_q   <= '0;
      res_valid_q <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            mat_q <= mat_in;
            vec_q <= vec_in;
            row   <= '0;
            col   <= '0;
            acc   <= '0;
            busy  <= 1'b1;
          end
        end
        S_MAC: begin
          acc <= acc_sum;
          col <= col + IDX_W'(1);
          if (col == LAST) begin
            res_data_q  <= acc_sum;
            res_row_q   <= row;
            res_valid_q <= 1'b1;
          end
        end
        S_OUT: begin
          if (handshake) begin
            res_valid_q <= 1'b0;
            if (row == LAST) begin
              busy <= 1'b0;
              done <= 1'b1;
            end else begin
              row <= row + IDX_W'(1);
              col <= '0;
              acc <= '0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign res_if.res_valid = res_valid_q;
  assign res_if.res_data  = res_data_q;
  assign res_if.res_row   = res_row_q;
  assign state_dbg        = state;

endmodule

// File: tb/tb_matvec_mac_sequencer.sv
// Bench for matvec_mac_sequencer: scoreboard of row results, latency, back-pressure and reset checks.
module tb_matvec_mac_sequencer;
  localparam int EW    = 3;
  localparam int N     = 3;
  localparam int ACC_W = 8;
  localparam int IDX_W = 2;
  localparam int W     = ACC_W + IDX_W;

  logic                clk = 1'b0;
  logic                rst;
  logic                start;
  logic [N*N*EW-1:0]   mat_in;
  logic [N*EW-1:0]     vec_in;
  logic                busy, done;
  logic [1:0]          state_dbg;

  matvec_mac_sequencer_if #(.ACC_W(ACC_W), .IDX_W(IDX_W)) res_if ();

  matvec_mac_sequencer #(.EW(EW), .N(N), .ACC_W(ACC_W), .IDX_W(IDX_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .mat_in    (mat_in),
    .vec_in    (vec_in),
    .busy      (busy),
    .done      (done),
    .state_dbg (state_dbg),
    .res_if    (res_if.master)
  );

  // clock / reset
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // scoreboard
  logic [W-1:0] exp_q[$];
  int done_cnt = 0;
  int done_cyc = 0;
  int first_valid_cyc = -1;
  bit stall_mode = 1'b0;

  function automatic logic [ACC_W-1:0] model(input logic [N*N*EW-1:0] m,
                                             input logic [N*EW-1:0] v, input int r);
    logic [ACC_W-1:0] sum;
    logic [ACC_W-1:0] e, ve;
    sum = '0;
    for (int c = 0; c < N; c++) begin
`ifdef MATVEC_TRANSPOSE_EN
      e = ACC_W'(m[EW*(N*c+r) +: EW]);
`else
      e = ACC_W'(m[EW*(N*r+c) +: EW]);
`endif
      ve  = ACC_W'(v[EW*c +: EW]);
      sum = sum + e * ve;
    end
    return sum;
  endfunction

  function automatic logic [N*N*EW-1:0] pack_m(input int k0, k1, k2, k3, k4, k5, k6, k7, k8);
    int k[9];
    logic [N*N*EW-1:0] m;
    k = '{k0, k1, k2, k3, k4, k5, k6, k7, k8};
    m = '0;
    for (int i = 0; i < N*N; i++) m[EW*i +: EW] = EW'(k[i]);
    return m;
  endfunction

  function automatic logic [N*EW-1:0] pack_v(input int a, b, c);
    return {EW'(c), EW'(b), EW'(a)};
  endfunction

  // consumer ready driver: always ready, or 5 stalled cycles per result
  initial begin
    int stall_cnt;
    stall_cnt = 0;
    res_if.res_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (!stall_mode) begin
        res_if.res_ready = 1'b1;
        stall_cnt = 0;
      end else if (res_if.res_valid) begin
        if (stall_cnt >= 5) res_if.res_ready = 1'b1;
        else begin
          res_if.res_ready = 1'b0;
          stall_cnt++;
        end
      end else begin
        res_if.res_ready = 1'b0;
        stall_cnt = 0;
      end
    end
  end

  // monitor: sampled on the falling edge, away from the active edge
  logic         prev_valid = 1'b0;
  logic         prev_ready = 1'b0;
  logic [W-1:0] prev_word  = '0;
  always @(negedge clk) begin
    logic [W-1:0] word, e;
    word = {res_if.res_row, res_if.res_data};
    if (rst) begin
      prev_valid = 1'b0;
    end else begin
      if (prev_valid && !prev_ready) begin
        check("hold_valid", res_if.res_valid, 1'b1);
        check("hold_data", word, prev_word);
      end
      if (res_if.res_valid && res_if.res_ready) begin
        if (exp_q.size() == 0) check("unexpected_result", word, '1);
        else begin
          e = exp_q.pop_front();
          check("result", word, e);
        end
      end
      if (res_if.res_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        check("done_vs_valid", res_if.res_valid, 1'b0);
      end
      prev_valid = res_if.res_valid;
      prev_ready = res_if.res_ready;
      prev_word  = word;
    end
  end

  // driver tasks
  task automatic run_job(input logic [N*N*EW-1:0] m, input logic [N*EW-1:0] v, input bit disturb);
    int d0, t0, waited;
    for (int r = 0; r < N; r++) exp_q.push_back({IDX_W'(r), model(m, v, r)});
    d0 = done_cnt;
    first_valid_cyc = -1;
    @(posedge clk); #1;
    mat_in = m;
    vec_in = v;
    start  = 1'b1;
    @(posedge clk); #1;
    t0 = cyc;
    start = 1'b0;
    check("busy_after_start", busy, 1'b1);
    if (disturb) begin
      mat_in = 27'($urandom);
      vec_in = 9'($urandom);
      repeat (2) @(posedge clk);
      #1 start = 1'b1;
      mat_in = 27'($urandom);
      @(posedge clk); #1 start = 1'b0;
      repeat (2) @(posedge clk);
      #1 start = 1'b1;
      vec_in = 9'($urandom);
      @(posedge clk); #1 start = 1'b0;
    end
    waited = 0;
    while (done_cnt == d0 && waited < 300) begin
      @(posedge clk);
      waited++;
    end
    check("done_seen", (done_cnt != d0), 1'b1);
    if (!stall_mode && !disturb) begin
      check("lat_valid", first_valid_cyc - t0, 3);
      check("lat_done", done_cyc - t0, 12);
    end
    repeat (3) @(posedge clk);
    #1;
    check("done_once", done_cnt - d0, 1);
    check("sb_empty", exp_q.size(), 0);
    check("busy_idle", busy, 1'b0);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_valid"}, res_if.res_valid, 1'b0);
    check({tag, "_data"}, res_if.res_data, '0);
    check({tag, "_row"}, res_if.res_row, '0);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_done"}, done, 1'b0);
    check({tag, "_state"}, state_dbg, 2'd0);
  endtask

  initial begin
    logic [N*N*EW-1:0] m_a;
    int d0, t0;
    rst    = 1'b1;
    start  = 1'b0;
    mat_in = '0;
    vec_in = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);
    #3 rst = 1'b1;
    #1 check_outputs_zero("rst_idle");
    @(posedge clk); #1 rst = 1'b0;

    m_a = pack_m(1, 2, 3, 3, 2, 1, 1, 2, 3);
    run_job(m_a, pack_v(1, 1, 1), 1'b0);
    run_job(m_a, pack_v(1, 2, 3), 1'b0);
    run_job('1, '1, 1'b0);

    stall_mode = 1'b1;
    run_job(m_a, pack_v(1, 2, 3), 1'b0);
    stall_mode = 1'b0;

    run_job(pack_m(7, 0, 5, 1, 6, 2, 3, 4, 7), pack_v(2, 7, 5), 1'b1);

    // reset while in MAC of row 1 aborts the job with no done
    for (int r = 0; r < N; r++) exp_q.push_back({IDX_W'(r), model(m_a, pack_v(1, 2, 3), r)});
    @(posedge clk); #1;
    mat_in = m_a;
    vec_in = pack_v(1, 2, 3);
    start  = 1'b1;
    @(posedge clk); #1;
    t0 = cyc;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #2 rst = 1'b1;
    #1 check_outputs_zero("rst_mid");
    exp_q.delete();
    d0 = done_cnt;
    @(negedge clk) rst = 1'b0;
    repeat (20) @(posedge clk);
    #1 check("no_done_after_rst", done_cnt - d0, 0);
    run_job(pack_m(4, 5, 6, 7, 0, 1, 2, 3, 4), pack_v(3, 6, 1), 1'b0);

    for (int j = 0; j < 4; j++)
      run_job(27'($urandom), 9'($urandom), 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=%0d exp=0", 1);
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
